// File: rtl/lc3_memory_responder.sv
// rtl/lc3_memory_responder.sv - LC-3 bus responder: word RAM, console registers, preload port
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   writeEnable         core write strobe, sampled on the rising edge
//   address             core word address (reads are combinational from it)
//   dataToMemory        core write data
//   dataFromMemory      read data for the current address
//   load_en/addr/data   preload write into RAM, honoured even in reset
//   kb_valid/kb_data    keyboard byte offered to the FIFO
//   kb_ready            FIFO not full
//   dsp_valid/dsp_data  display byte pending
//   dsp_ready           display consumer accepts the pending byte

module lc3_memory_responder #(
    parameter int ADDR_BITS = 12,
    parameter int KB_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEnable,
    input  logic [15:0] address,
    input  logic [15:0] dataToMemory,
    output logic [15:0] dataFromMemory,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready
);

    localparam int          RAM_WORDS = 1 << ADDR_BITS;
    localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);
    localparam int          PTR_W     = $clog2(KB_DEPTH);
    localparam logic [PTR_W:0] KB_FULL = (PTR_W + 1)'(KB_DEPTH);

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    // ---------------------------------------------------------------- RAM
    logic [15:0] ram [RAM_WORDS];

    logic addr_in_ram;
    logic load_in_ram;
    logic core_we;

    assign addr_in_ram = ({1'b0, address} < RAM_LIMIT);
    assign load_in_ram = ({1'b0, load_addr} < RAM_LIMIT);
    // Preload owns the cycle: any core write that coincides with it is lost.
    assign core_we     = writeEnable && !load_en && !reset;

    // RAM is deliberately not reset so a program preloaded under reset survives.
    always_ff @(posedge clk) begin
        if (load_en) begin
            if (load_in_ram) begin
                ram[load_addr[ADDR_BITS-1:0]] <= load_data;
            end
        end else if (core_we && addr_in_ram) begin
            ram[address[ADDR_BITS-1:0]] <= dataToMemory;
        end
    end

    // ------------------------------------------------ previous address
    logic [15:0] addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= 16'hFFFF;
        end else begin
            addr_q <= address;
        end
    end

    // A KBDR access pops only on its first cycle, so a core that holds the
    // address for several cycles still consumes exactly one byte.
    logic kbdr_first;
    assign kbdr_first = (address == KBDR_ADDR) && (addr_q != KBDR_ADDR);

    // ------------------------------------------------------ keyboard FIFO
    logic [7:0]     kb_fifo [KB_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   kb_count;
    logic [7:0]     kbdr_hold;
    logic [7:0]     fifo_head;
    logic           fifo_empty;
    logic           fifo_full;
    logic           kb_push;
    logic           kb_pop;

    assign fifo_empty = (kb_count == '0);
    assign fifo_full  = (kb_count == KB_FULL);
    assign fifo_head  = kb_fifo[rd_ptr];
    assign kb_ready   = !fifo_full;
    assign kb_push    = kb_valid && !fifo_full;
    assign kb_pop     = kbdr_first && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset && kb_push) begin
            kb_fifo[wr_ptr] <= kb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            kb_count  <= '0;
            kbdr_hold <= 8'h00;
        end else begin
            if (kb_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (kb_pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                kbdr_hold <= fifo_head;
            end
            case ({kb_push, kb_pop})
                2'b10:   kb_count <= kb_count + (PTR_W + 1)'(1);
                2'b01:   kb_count <= kb_count - (PTR_W + 1)'(1);
                default: kb_count <= kb_count;
            endcase
        end
    end

    // ---------------------------------------------------- display handshake
    logic ddr_write;
    assign ddr_write = core_we && (address == DDR_ADDR);

    // dsp_valid is sampled pre-edge, so a DDR write on the clearing edge is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_valid <= 1'b0;
            dsp_data  <= 8'h00;
        end else if (dsp_valid) begin
            if (dsp_ready) begin
                dsp_valid <= 1'b0;
            end
        end else if (ddr_write) begin
            dsp_valid <= 1'b1;
            dsp_data  <= dataToMemory[7:0];
        end
    end

    // ------------------------------------------------------------ read mux
    always_comb begin
        dataFromMemory = 16'h0000;
        if (addr_in_ram) begin
            dataFromMemory = ram[address[ADDR_BITS-1:0]];
        end else begin
            case (address)
                KBSR_ADDR: dataFromMemory = {!fifo_empty, 15'b0};
                KBDR_ADDR: dataFromMemory = {8'h00, kb_pop ? fifo_head : kbdr_hold};
                DSR_ADDR:  dataFromMemory = {!dsp_valid, 15'b0};
                DDR_ADDR:  dataFromMemory = {8'h00, dsp_data};
                default:   dataFromMemory = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_memory_responder.sv
// tb/tb_lc3_memory_responder.sv - directed and randomized checks of lc3_memory_responder

module tb_lc3_memory_responder;

    logic        clk;
    logic        rst;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] dfm;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        kbv;
    logic [7:0]  kbd;
    logic        kb_rdy;
    logic        dv;
    logic [7:0]  dd;
    logic        drdy;

    lc3_memory_responder dut (
        .clk            (clk),
        .reset          (rst),
        .writeEnable    (we),
        .address        (addr),
        .dataToMemory   (wdata),
        .dataFromMemory (dfm),
        .load_en        (ld_en),
        .load_addr      (ld_addr),
        .load_data      (ld_data),
        .kb_valid       (kbv),
        .kb_data        (kbd),
        .kb_ready       (kb_rdy),
        .dsp_valid      (dv),
        .dsp_data       (dd),
        .dsp_ready      (drdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: RAM array with written flags, byte queue, display latch.
    logic [15:0] ram_m   [4096];
    bit          known_m [4096];
    logic [7:0]  kbq [$];
    logic [7:0]  hold_m;
    bit          dv_m;
    logic [7:0]  dd_m;
    logic [15:0] prev_m;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'd4096) return ram_m[a[11:0]];
        case (a)
            16'hFE00: return (kbq.size() != 0) ? 16'h8000 : 16'h0000;
            16'hFE02: begin
                if (prev_m != 16'hFE02 && kbq.size() != 0) return {8'h00, kbq[0]};
                return {8'h00, hold_m};
            end
            16'hFE04: return dv_m ? 16'h0000 : 16'h8000;
            16'hFE06: return {8'h00, dd_m};
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic bit model_known(input logic [15:0] a);
        return (a >= 16'd4096) || known_m[a[11:0]];
    endfunction

    task automatic model_edge();
        bit do_push;
        bit do_pop;
        if (ld_en && ld_addr < 16'd4096) begin
            ram_m[ld_addr[11:0]] = ld_data;
            known_m[ld_addr[11:0]] = 1'b1;
        end
        if (rst) begin
            kbq.delete();
            hold_m = 8'h00;
            dv_m   = 1'b0;
            dd_m   = 8'h00;
            prev_m = 16'hFFFF;
        end else begin
            do_push = kbv && (kbq.size() < 4);
            do_pop  = (addr == 16'hFE02) && (prev_m != 16'hFE02) && (kbq.size() != 0);
            if (we && !ld_en && addr < 16'd4096) begin
                ram_m[addr[11:0]] = wdata;
                known_m[addr[11:0]] = 1'b1;
            end
            if (dv_m && drdy) begin
                dv_m = 1'b0;
            end else if (!dv_m && we && !ld_en && addr == 16'hFE06) begin
                dv_m = 1'b1;
                dd_m = wdata[7:0];
            end
            if (do_pop) hold_m = kbq.pop_front();
            if (do_push) kbq.push_back(kbd);
            prev_m = addr;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        if (model_known(addr)) chk({tag, ":rd"}, dfm, model_read(addr));
        chk({tag, ":kb_ready"}, {15'b0, kb_rdy}, {15'b0, (kbq.size() < 4)});
        chk({tag, ":dsp_valid"}, {15'b0, dv}, {15'b0, dv_m});
        chk({tag, ":dsp_data"}, {8'h00, dd}, {8'h00, dd_m});
    endtask

    task automatic idle();
        we = 1'b0; wdata = 16'h0000; ld_en = 1'b0; ld_addr = 16'h0000; ld_data = 16'h0000;
        kbv = 1'b0; kbd = 8'h00; drdy = 1'b0; addr = 16'h2000;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_m[i] = 16'h0000;
            known_m[i] = 1'b0;
        end
        hold_m = 8'h00; dv_m = 1'b0; dd_m = 8'h00; prev_m = 16'hFFFF;
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("reset_kb_ready", {15'b0, kb_rdy}, 16'h0001);
        chk("reset_dsp_valid", {15'b0, dv}, 16'h0000);
        chk("reset_dsp_data", {8'h00, dd}, 16'h0000);

        // Preload under reset, then read back.
        ld_en = 1'b1; ld_addr = 16'd0; ld_data = 16'h1261; tick();
        ld_addr = 16'd5; ld_data = 16'hABCD; tick();
        idle(); rst = 1'b0; tick();
        addr = 16'd0;    #1; chk("preload_0", dfm, 16'h1261);
        addr = 16'd5;    #1; chk("preload_5", dfm, 16'hABCD);
        addr = 16'h2000; #1; chk("unmapped", dfm, 16'h0000);

        // Core write, then preload priority on the same address.
        we = 1'b1; addr = 16'd3; wdata = 16'h00FF; tick();
        we = 1'b0; #1; chk("core_write", dfm, 16'h00FF);
        we = 1'b1; wdata = 16'h2222; ld_en = 1'b1; ld_addr = 16'd3; ld_data = 16'h1111; tick();
        we = 1'b0; ld_en = 1'b0; #1; chk("load_priority", dfm, 16'h1111);

        // Keyboard push and single-pop KBDR access.
        idle();
        kbv = 1'b1; kbd = 8'h41; tick();
        kbd = 8'h42; tick();
        kbv = 1'b0; addr = 16'hFE00; #1; chk("kbsr_nonempty", dfm, 16'h8000);
        addr = 16'hFE02;
        for (int i = 0; i < 3; i++) begin
            #1; chk("kbdr_hold_A", dfm, 16'h0041); tick();
        end
        addr = 16'h2000; tick();
        addr = 16'hFE02; #1; chk("kbdr_B", dfm, 16'h0042); tick();
        addr = 16'hFE00; #1; chk("kbsr_empty", dfm, 16'h0000);

        // Full FIFO and pointer wrap.
        addr = 16'h2000;
        for (int i = 0; i < 5; i++) begin
            kbv = 1'b1; kbd = 8'h10 + 8'(i); #1;
            chk("fill_ready", {15'b0, kb_rdy}, (i < 4) ? 16'h0001 : 16'h0000);
            tick();
        end
        kbv = 1'b0; #1; chk("full_ready", {15'b0, kb_rdy}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            addr = 16'hFE02; #1; chk("pop_first", dfm, 16'h0010 + 16'(i)); tick();
            addr = 16'h2000; tick();
        end
        for (int i = 0; i < 4; i++) begin
            kbv = 1'b1; kbd = 8'h20 + 8'(i); tick();
        end
        kbv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 16'hFE02; #1; chk("pop_wrap", dfm, 16'h0020 + 16'(i)); tick();
            addr = 16'h2000; tick();
        end
        kbv = 1'b1; kbd = 8'h30; tick();
        kbd = 8'h31; tick();
        addr = 16'hFE02; kbd = 8'h32; #1; chk("pushpop_rd", dfm, 16'h0030); tick();
        kbv = 1'b0; addr = 16'h2000; tick();
        for (int i = 0; i < 2; i++) begin
            addr = 16'hFE02; #1; chk("pushpop_rest", dfm, 16'h0031 + 16'(i)); tick();
            addr = 16'h2000; tick();
        end
        addr = 16'hFE00; #1; chk("pushpop_empty", dfm, 16'h0000);

        // Display handshake.
        we = 1'b1; addr = 16'hFE06; wdata = 16'h0048; tick();
        we = 1'b0; addr = 16'hFE04; #1;
        chk("dsp_valid_set", {15'b0, dv}, 16'h0001);
        chk("dsp_data_48", {8'h00, dd}, 16'h0048);
        chk("dsr_busy", dfm, 16'h0000);
        we = 1'b1; addr = 16'hFE06; wdata = 16'h0049; tick();
        we = 1'b0; #1; chk("ddr_drop", {8'h00, dd}, 16'h0048);
        drdy = 1'b1; tick();
        drdy = 1'b0; addr = 16'hFE04; #1;
        chk("dsp_cleared", {15'b0, dv}, 16'h0000);
        chk("dsr_ready", dfm, 16'h8000);

        // Reset in the middle of activity.
        addr = 16'h2000;
        kbv = 1'b1; kbd = 8'h50; tick();
        kbd = 8'h51; we = 1'b1; addr = 16'hFE06; wdata = 16'h0055; tick();
        kbv = 1'b0; we = 1'b0; addr = 16'h2000; #1;
        chk("pre_reset_dv", {15'b0, dv}, 16'h0001);
        rst = 1'b1; tick();
        rst = 1'b0; #1;
        chk("rst_kb_ready", {15'b0, kb_rdy}, 16'h0001);
        chk("rst_dsp_valid", {15'b0, dv}, 16'h0000);
        addr = 16'hFE00; #1; chk("rst_kbsr", dfm, 16'h0000);
        addr = 16'd5;    #1; chk("rst_ram5", dfm, 16'hABCD);
        chk_all("post_reset");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(2) != 0) begin
                case ($urandom_range(5))
                    0, 1:    addr = 16'($urandom_range(15));
                    2:       addr = 16'hFE00 + 16'(2 * $urandom_range(3));
                    3:       addr = 16'hFE02;
                    4:       addr = 16'hFE06;
                    default: addr = ($urandom_range(1) != 0) ? 16'h2000 : 16'hFFFF;
                endcase
            end
            we      = ($urandom_range(3) == 0);
            wdata   = 16'($urandom);
            ld_en   = ($urandom_range(7) == 0);
            ld_addr = ($urandom_range(7) == 0) ? 16'h3000 : 16'($urandom_range(15));
            ld_data = 16'($urandom);
            kbv     = $urandom_range(1) != 0;
            kbd     = 8'($urandom);
            drdy    = $urandom_range(1) != 0;
            rst     = ($urandom_range(49) == 0);
            #1;
            chk_all("rand");
            tick();
        end
        idle(); rst = 1'b0; #1;
        chk_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
